// File: rtl/fft_set_serializer_if.sv
// Stream bundle between the FFT register bank, the set serializer and the downstream consumer.
// The master side drives the parallel group and dout_ready; the slave side is the serializer.
interface fft_set_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] SET_0_IN;
  logic [DATA_WIDTH-1:0] SET_1_IN;
  logic [DATA_WIDTH-1:0] SET_2_IN;
  logic [DATA_WIDTH-1:0] SET_3_IN;
  logic [DATA_WIDTH-1:0] SET_4_IN;
  logic [DATA_WIDTH-1:0] SET_5_IN;
  logic [DATA_WIDTH-1:0] SET_6_IN;
  logic [DATA_WIDTH-1:0] SET_7_IN;
  logic                  in_valid;
  logic                  hold;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;
  logic                  dout_frame_last;
  logic [7:0]            frame_count;

  modport master (
    output SET_0_IN, SET_1_IN, SET_2_IN, SET_3_IN,
    output SET_4_IN, SET_5_IN, SET_6_IN, SET_7_IN,
    output in_valid, dout_ready,
    input  hold, in_ready, dout, dout_valid, dout_last, dout_frame_last, frame_count
  );

  modport slave (
    input  SET_0_IN, SET_1_IN, SET_2_IN, SET_3_IN,
    input  SET_4_IN, SET_5_IN, SET_6_IN, SET_7_IN,
    input  in_valid, dout_ready,
    output hold, in_ready, dout, dout_valid, dout_last, dout_frame_last, frame_count
  );
endinterface

// File: rtl/fft_set_serializer.sv
// Serializes one group of eight complex sets per transfer onto a valid/ready stream, with
// group-last / frame-last markers and a hold back-pressure signal to the register bank.
module fft_set_serializer #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned GROUPS_PER_FRAME = 8,
  parameter int unsigned BIT_REVERSE      = 0
) (
  input logic                clk,
  input logic                rst,
  fft_set_serializer_if.slave bus
);
  localparam int unsigned GW = (GROUPS_PER_FRAME > 1) ? $clog2(GROUPS_PER_FRAME) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] buf_q [8];
  logic [DATA_WIDTH-1:0] set_in [8];
  logic [2:0]            idx_q;
  logic [2:0]            idx_nxt;
  logic [GW-1:0]         grp_q;
  logic [7:0]            frame_count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  dout_last_q;
  logic                  dout_frame_last_q;

  logic in_ready;
  logic accept;
  logic beat;
  logic final_beat;
  logic grp_last;

  function automatic logic [2:0] order(input logic [2:0] i);
    if (BIT_REVERSE != 0) return {i[0], i[1], i[2]};
    return i;
  endfunction

  assign set_in[0] = bus.SET_0_IN;
  assign set_in[1] = bus.SET_1_IN;
  assign set_in[2] = bus.SET_2_IN;
  assign set_in[3] = bus.SET_3_IN;
  assign set_in[4] = bus.SET_4_IN;
  assign set_in[5] = bus.SET_5_IN;
  assign set_in[6] = bus.SET_6_IN;
  assign set_in[7] = bus.SET_7_IN;

  // Ready on the last beat too, so a waiting group slides in with no bubble.
  assign in_ready   = (state_q == StIdle) || ((idx_q == 3'd7) && bus.dout_ready);
  assign accept     = bus.in_valid && in_ready;
  assign beat       = dout_valid_q && bus.dout_ready;
  assign final_beat = beat && (idx_q == 3'd7);
  assign grp_last   = (grp_q == GW'(GROUPS_PER_FRAME - 1));
  assign idx_nxt    = idx_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      idx_q             <= 3'd0;
      grp_q             <= '0;
      frame_count_q     <= 8'd0;
      dout_q            <= '0;
      dout_valid_q      <= 1'b0;
      dout_last_q       <= 1'b0;
      dout_frame_last_q <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      if (final_beat) begin
        if (grp_last) begin
          grp_q         <= '0;
          frame_count_q <= frame_count_q + 8'd1;
        end else begin
          grp_q <= grp_q + GW'(1);
        end
      end

      if (accept) begin
        for (int i = 0; i < 8; i++) buf_q[i] <= set_in[i];
        state_q           <= StSend;
        idx_q             <= 3'd0;
        dout_q            <= set_in[order(3'd0)];
        dout_valid_q      <= 1'b1;
        dout_last_q       <= 1'b0;
        dout_frame_last_q <= 1'b0;
      end else if (final_beat) begin
        state_q           <= StIdle;
        idx_q             <= 3'd0;
        dout_valid_q      <= 1'b0;
        dout_last_q       <= 1'b0;
        dout_frame_last_q <= 1'b0;
      end else if (beat) begin
        idx_q             <= idx_nxt;
        dout_q            <= buf_q[order(idx_nxt)];
        dout_last_q       <= (idx_nxt == 3'd7);
        dout_frame_last_q <= (idx_nxt == 3'd7) && grp_last;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.hold            = ~in_ready;
  assign bus.dout            = dout_q;
  assign bus.dout_valid      = dout_valid_q;
  assign bus.dout_last       = dout_last_q;
  assign bus.dout_frame_last = dout_frame_last_q;
  assign bus.frame_count     = frame_count_q;
endmodule

// File: tb/tb_fft_set_serializer.sv
// Directed bench for fft_set_serializer: in-order and bit-reversed instances, stall,
// back-to-back frame, mid-group reset and ignored in_valid pulses.
module tb_fft_set_serializer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fft_set_serializer_if #(.DATA_WIDTH(32)) bus ();
  fft_set_serializer_if #(.DATA_WIDTH(32)) rbus ();

  fft_set_serializer #(
    .DATA_WIDTH(32), .GROUPS_PER_FRAME(8), .BIT_REVERSE(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  fft_set_serializer #(
    .DATA_WIDTH(32), .GROUPS_PER_FRAME(8), .BIT_REVERSE(1)
  ) dut_rev (
    .clk(clk), .rst(rst), .bus(rbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_group(input logic [31:0] base, input logic [31:0] stride);
    bus.SET_0_IN = base;
    bus.SET_1_IN = base + stride;
    bus.SET_2_IN = base + 2 * stride;
    bus.SET_3_IN = base + 3 * stride;
    bus.SET_4_IN = base + 4 * stride;
    bus.SET_5_IN = base + 5 * stride;
    bus.SET_6_IN = base + 6 * stride;
    bus.SET_7_IN = base + 7 * stride;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    rbus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 ||
        bus.dout_frame_last !== 1'b0 || bus.frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h v=%b l=%b fl=%b fc=%0d, required all zero",
               bus.dout, bus.dout_valid, bus.dout_last, bus.dout_frame_last, bus.frame_count);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b hold=%b, required 1/0", bus.in_ready, bus.hold);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_group();
    logic [31:0] exp;
    do_reset();
    drive_group(32'h0, 32'h0001_0001);
    bus.in_valid = 1'b1;
    bus.dout_ready = 1'b1;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_accept: v=%b in_ready=%b, required 0/1",
               bus.dout_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      exp = 32'h0001_0001 * b;
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== exp || bus.dout_last !== (b == 7) ||
          bus.dout_frame_last !== 1'b0) begin
        errors++;
        $display("FAIL single_beat%0d: v=%b dout=%h l=%b fl=%b, required 1 %h %b 0",
                 b, bus.dout_valid, bus.dout, bus.dout_last, bus.dout_frame_last, exp, b == 7);
      end
      checks++;
      if (bus.hold !== (b != 7)) begin
        errors++;
        $display("FAIL single_hold%0d: hold=%b, required %b", b, bus.hold, b != 7);
      end
      tick();
    end
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: v=%b in_ready=%b, required 0/1", bus.dout_valid, bus.in_ready);
    end
  endtask

  // Eight back-to-back groups; group g carries base + g*16 + k.
  task automatic test_frame(input bit with_reset, input logic [31:0] base);
    logic [31:0] exp;
    int g;
    int k;
    if (with_reset) do_reset();
    drive_group(base, 32'd1);
    bus.in_valid = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    for (int n = 0; n < 64; n++) begin
      g = n / 8;
      k = n % 8;
      exp = base + 32'(g * 16 + k);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== exp || bus.dout_last !== (k == 7) ||
          bus.dout_frame_last !== (n == 63) || bus.frame_count !== 8'd0) begin
        errors++;
        $display("FAIL frame_beat%0d: v=%b dout=%h l=%b fl=%b fc=%0d, required 1 %h %b %b 0",
                 n, bus.dout_valid, bus.dout, bus.dout_last, bus.dout_frame_last,
                 bus.frame_count, exp, k == 7, n == 63);
      end
      if (k == 7) begin
        if (g < 7) drive_group(base + 32'((g + 1) * 16), 32'd1);
        else bus.in_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (bus.frame_count !== 8'd1 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: fc=%0d v=%b, required 1/0", bus.frame_count, bus.dout_valid);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    int beats;
    pat = 4'b1001;
    beats = 0;
    do_reset();
    drive_group(32'hA0, 32'd1);
    bus.in_valid = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
      bus.dout_ready = pat[cyc % 4];
      #1;
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'(32'hA0 + beats) ||
          bus.dout_last !== (beats == 7)) begin
        errors++;
        $display("FAIL stall_cyc%0d: v=%b dout=%h l=%b, required 1 %h %b", cyc,
                 bus.dout_valid, bus.dout, bus.dout_last, 32'hA0 + beats, beats == 7);
      end
      checks++;
      if (bus.in_ready !== (beats == 7 && bus.dout_ready)) begin
        errors++;
        $display("FAIL stall_ready%0d: in_ready=%b, required %b", cyc, bus.in_ready,
                 beats == 7 && bus.dout_ready);
      end
      if (bus.dout_ready) beats++;
      tick();
    end
    bus.dout_ready = 1'b1;
    checks++;
    if (beats != 8 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: beats=%0d v=%b, required 8/0", beats, bus.dout_valid);
    end
  endtask

  task automatic test_bit_reverse();
    logic [31:0] rev_seq [8];
    rev_seq = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    do_reset();
    rbus.SET_0_IN = 32'd0; rbus.SET_1_IN = 32'd1; rbus.SET_2_IN = 32'd2; rbus.SET_3_IN = 32'd3;
    rbus.SET_4_IN = 32'd4; rbus.SET_5_IN = 32'd5; rbus.SET_6_IN = 32'd6; rbus.SET_7_IN = 32'd7;
    rbus.in_valid = 1'b1;
    rbus.dout_ready = 1'b1;
    tick();
    rbus.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rbus.dout_valid !== 1'b1 || rbus.dout !== rev_seq[b] || rbus.dout_last !== (b == 7)) begin
        errors++;
        $display("FAIL bitrev_beat%0d: v=%b dout=%h l=%b, required 1 %h %b", b,
                 rbus.dout_valid, rbus.dout, rbus.dout_last, rev_seq[b], b == 7);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    drive_group(32'h0, 32'd1);
    bus.in_valid = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    for (int n = 0; n < 11; n++) begin
      if (n == 7) drive_group(32'h10, 32'd1);
      if (n == 8) bus.in_valid = 1'b0;
      tick();
    end
    checks++;
    if (bus.dout !== 32'h13 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: dout=%h v=%b, required 00000013/1", bus.dout, bus.dout_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 ||
        bus.dout_frame_last !== 1'b0 || bus.frame_count !== 8'd0 ||
        bus.in_ready !== 1'b1 || bus.hold !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: dout=%h v=%b l=%b fl=%b fc=%0d rdy=%b hold=%b, required reset",
               bus.dout, bus.dout_valid, bus.dout_last, bus.dout_frame_last,
               bus.frame_count, bus.in_ready, bus.hold);
    end
    tick();
    rst = 1'b0;
    test_frame(1'b0, 32'h0300);
  endtask

  task automatic test_ignored_pulse();
    do_reset();
    drive_group(32'hC0, 32'd1);
    bus.in_valid = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'(32'hC0 + b)) begin
        errors++;
        $display("FAIL pulse_beat%0d: v=%b dout=%h, required 1 %h", b, bus.dout_valid,
                 bus.dout, 32'hC0 + b);
      end
      if (b == 2) begin
        drive_group(32'hDEAD_0000, 32'd1);
        bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL pulse_ready: in_ready=%b, required 0", bus.in_ready);
        end
      end
      if (b == 3) bus.in_valid = 1'b0;
      if (b == 7) begin
        drive_group(32'hE0, 32'd1);
        bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL pulse_final_ready: in_ready=%b, required 1", bus.in_ready);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'(32'hE0 + b) || bus.dout_last !== (b == 7)) begin
        errors++;
        $display("FAIL clean_beat%0d: v=%b dout=%h l=%b, required 1 %h %b", b,
                 bus.dout_valid, bus.dout, bus.dout_last, 32'hE0 + b, b == 7);
      end
      tick();
    end
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_idle: v=%b, required 0", bus.dout_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_group(32'h0, 32'h0);
    bus.in_valid = 1'b0;
    bus.dout_ready = 1'b0;
    rbus.SET_0_IN = '0; rbus.SET_1_IN = '0; rbus.SET_2_IN = '0; rbus.SET_3_IN = '0;
    rbus.SET_4_IN = '0; rbus.SET_5_IN = '0; rbus.SET_6_IN = '0; rbus.SET_7_IN = '0;
    rbus.in_valid = 1'b0;
    rbus.dout_ready = 1'b0;
    test_reset();
    test_single_group();
    test_frame(1'b1, 32'h0100);
    test_stall();
    test_bit_reverse();
    test_reset_mid_group();
    test_ignored_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_set_serializer.md
Name: fft_set_serializer

Overview:
- Drains one group of eight 32-bit complex sets per transfer from the inter-stage register bank at the FFT output.
- Presents the sets one word per beat on a valid/ready stream, with group-last and frame-last markers for a 64-point frame (8 groups x 8 sets).
- While a group is being drained it drives hold back to the upstream register bank, which freezes the pipeline.

Parameters:
- DATA_WIDTH, 32, width of each set word; [31:16] real, [15:0] imag, two's complement.
- GROUPS_PER_FRAME, 8, groups per FFT frame; must be >= 1 and a power of two.
- BIT_REVERSE, 0, 0 = emit sets in order 0..7; 1 = emit in 3-bit bit-reversed order 0,4,2,6,1,5,3,7.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- SET_0_IN..SET_7_IN  input  DATA_WIDTH each  parallel group from the register bank.
- in_valid  input  1  the group on SET_x_IN is valid.
- hold  output  1  freezes the upstream register bank; hold = ~in_ready.
- in_ready  output  1  the serializer accepts a group this cycle.
- dout  output  DATA_WIDTH  serialized set word.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream accepts dout.
- dout_last  output  1  last set of the current group.
- dout_frame_last  output  1  last set of the last group in the frame.
- frame_count  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - dout = 0, dout_valid = 0, dout_last = 0, dout_frame_last = 0, frame_count = 0.
  - Set index = 0, group index = 0, state = IDLE.
  - in_ready = 1, hold = 0.
- States:
  - IDLE: buffer empty. in_ready = 1.
  - SEND: buffer holds 8 words; dout_valid = 1.
- Accept: a group is accepted on a clock edge when in_valid && in_ready.
  - All eight inputs are captured into an internal 8 x DATA_WIDTH buffer.
  - Set index resets to 0.
  - State becomes SEND.
- Latency: the first word appears on dout with dout_valid = 1 in the cycle after acceptance.
- Beat: a beat completes on a clock edge when dout_valid && dout_ready.
  - The set index increments on each completed beat.
  - dout = buffer[order(index)], where order() is the identity or the 3-bit reverse, selected by BIT_REVERSE.
- Stall: when dout_valid && !dout_ready, dout, dout_last and dout_frame_last hold stable and the index does not advance.
- dout_last = 1 when index == 7.
- dout_frame_last = dout_last && (group index == GROUPS_PER_FRAME-1).
- in_ready = (state == IDLE) || (index == 7 && dout_ready). This is combinational and allows back-to-back groups with no bubble.
- On the final beat of a group:
  - If in_valid is high in that cycle, the new group is captured on the same edge and the state stays SEND with index 0.
  - Otherwise the state returns to IDLE and dout_valid = 0 next cycle.
- Group index increments on each final beat.
  - On the final beat of a frame (dout_frame_last handshake), the group index wraps to 0 and frame_count increments.
- in_valid is ignored while in_ready = 0. The buffer is never overwritten mid-group.
- Reset asserted mid-group: the partial group and partial frame are discarded and the block returns to reset values.
- No arithmetic on the data: words pass through bit-exact.

Test Plan:
1. Reset, then one group with SET_k = 0x0001_0000*k + k, dout_ready = 1 continuously.
   - Required: dout_valid rises 1 cycle after acceptance.
   - Required: dout = 0x00000000, 0x00010001, ..., 0x00070007 on consecutive cycles; dout_last only on the 8th beat.
   - Required: hold high for beats 1-7.
2. Eight consecutive groups, in_valid held high, dout_ready = 1.
   - Required: 64 beats with no bubble.
   - Required: dout_frame_last only on beat 64; frame_count 0 -> 1 at that edge.
3. dout_ready toggles 1,0,0,1 during a group.
   - Required: dout stays stable while stalled; the group still completes in 8 accepted beats.
   - Required: in_ready stays 0 until the final beat is accepted.
4. BIT_REVERSE = 1 with SET_k = k.
   - Required: dout sequence 0,4,2,6,1,5,3,7.
5. Assert rst after the 3rd beat of the 2nd group.
   - Required: all outputs return to reset values immediately.
   - Required: the next group restarts at set 0, group index 0.
6. in_valid pulsed during a group, then a clean group after it.
   - Required: the pulse is ignored and the buffer is unchanged.
   - Required: the next group is accepted only on an in_ready edge.
